// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and the issue (scoreboard set) port.
// Fields are packed flat, one AW/DATA_W-wide slice per port.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]     raddr;
   logic [NRD*DATA_W-1:0] rdata;
   logic [NRD-1:0]        rbusy;
   logic [NWR-1:0]        wen;
   logic [NWR*AW-1:0]     waddr;
   logic [NWR*DATA_W-1:0] wdata;
   logic                  iss_en;
   logic [AW-1:0]         iss_addr;

   modport master (
      output raddr, wen, waddr, wdata, iss_en, iss_addr,
      input  rdata, rbusy
   );

   modport slave (
      input  raddr, wen, waddr, wdata, iss_en, iss_addr,
      output rdata, rbusy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy scoreboard; register 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy clear) onto the read ports.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_mp_if.slave rf
);
   localparam int AW = $clog2(NREGS);

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy;

   // Later ports overwrite earlier ones via NBA ordering; the issue set comes last so it wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (rf.wen[j] && (rf.waddr[j*AW +: AW] != '0)) begin
               regs[rf.waddr[j*AW +: AW]] <= rf.wdata[j*DATA_W +: DATA_W];
               busy[rf.waddr[j*AW +: AW]] <= 1'b0;
            end
         end
         if (rf.iss_en && (rf.iss_addr != '0)) begin
            busy[rf.iss_addr] <= 1'b1;
         end
      end
   end

   logic [DATA_W-1:0] rd_v [NRD];
   logic              rb_v [NRD];

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_v[i] = regs[rf.raddr[i*AW +: AW]];
         rb_v[i] = busy[rf.raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
         for (int j = 0; j < NWR; j++) begin
            if (rf.wen[j] && (rf.waddr[j*AW +: AW] == rf.raddr[i*AW +: AW]) &&
                (rf.raddr[i*AW +: AW] != '0)) begin
               rd_v[i] = rf.wdata[j*DATA_W +: DATA_W];
               rb_v[i] = rf.iss_en && (rf.iss_addr == rf.raddr[i*AW +: AW]);
            end
         end
`endif
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      assign rf.rdata[g*DATA_W +: DATA_W] = rd_v[g];
      assign rf.rbusy[g]                  = rb_v[g];
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NREGS=16, DATA_W=64, NRD=3, NWR=2): directed table,
// hand sequences for reset/scoreboard/bypass, and random traffic against a behavioural model.
module tb_regfile_mp;
   localparam int DW  = 64;
   localparam int NR  = 16;
   localparam int NRD = 3;
   localparam int NWR = 2;
   localparam int AW  = $clog2(NR);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus ();

   regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] m_regs [NR];
   logic          m_busy [NR];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic          w0_en;
      logic [AW-1:0] w0_addr;
      logic [DW-1:0] w0_data;
      logic          w1_en;
      logic [AW-1:0] w1_addr;
      logic [DW-1:0] w1_data;
      logic          iss_en;
      logic [AW-1:0] iss_addr;
      logic [AW-1:0] rd_addr;
      logic [DW-1:0] exp_data;
      logic          exp_busy;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < NR; a++) begin
         m_regs[a] = '0;
         m_busy[a] = 1'b0;
      end
   endtask

   // Next state per register: highest-index writer supplies data; a same-cycle issue keeps it busy.
   task automatic model_edge(input logic [NWR-1:0] we, input logic [NWR*AW-1:0] wa,
                             input logic [NWR*DW-1:0] wd, input logic ie, input logic [AW-1:0] ia);
      for (int a = 1; a < NR; a++) begin
         int w;
         w = -1;
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wa[j*AW +: AW] == AW'(a))) w = j;
         end
         if (w >= 0) m_regs[a] = wd[w*DW +: DW];
         if (ie && (ia == AW'(a))) m_busy[a] = 1'b1;
         else if (w >= 0)          m_busy[a] = 1'b0;
      end
   endtask

   task automatic tick();
      logic [NWR-1:0]    we;
      logic [NWR*AW-1:0] wa;
      logic [NWR*DW-1:0] wd;
      logic              ie;
      logic [AW-1:0]     ia;
      we = bus.wen; wa = bus.waddr; wd = bus.wdata; ie = bus.iss_en; ia = bus.iss_addr;
      @(posedge clk);
      if (rst_n) model_edge(we, wa, wd, ie, ia);
      #1;
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      d = m_regs[a];
      if (BYP) begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.wen[j] && (bus.waddr[j*AW +: AW] == a)) d = bus.wdata[j*DW +: DW];
         end
      end
      if (a == '0) d = '0;
      return d;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      logic b;
      b = m_busy[a];
      if (BYP) begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.wen[j] && (bus.waddr[j*AW +: AW] == a)) b = bus.iss_en && (bus.iss_addr == a);
         end
      end
      if (a == '0) b = 1'b0;
      return b;
   endfunction

   task automatic check_ports(input string name);
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0] a;
         a = bus.raddr[i*AW +: AW];
         chk({name, "_rdata"}, bus.rdata[i*DW +: DW], exp_data(a));
         chk({name, "_rbusy"}, DW'(bus.rbusy[i]), DW'(exp_busy(a)));
      end
   endtask

   task automatic idle();
      bus.wen = '0; bus.waddr = '0; bus.wdata = '0; bus.iss_en = 1'b0; bus.iss_addr = '0;
   endtask

   task automatic set_w(input int j, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.wen[j] = en;
      bus.waddr[j*AW +: AW] = a;
      bus.wdata[j*DW +: DW] = d;
   endtask

   task automatic set_rd(input logic [AW-1:0] a);
      bus.raddr = {NRD{a}};
   endtask

   task automatic check_all_zero(input string name);
      for (int a = 0; a < NR; a++) begin
         bus.raddr[0 +: AW]    = AW'(a);
         bus.raddr[AW +: AW]   = AW'((a + 5) % NR);
         bus.raddr[2*AW +: AW] = AW'((a + 11) % NR);
         #1;
         for (int i = 0; i < NRD; i++) begin
            chk({name, "_rdata"}, bus.rdata[i*DW +: DW], '0);
            chk({name, "_rbusy"}, DW'(bus.rbusy[i]), '0);
         end
      end
   endtask

   initial begin
      vecs[0] = '{1, 4'd3, 64'h1234, 0, 4'd0, 64'h0, 0, 4'd0, 4'd3, 64'h1234, 0};
      vecs[1] = '{1, 4'd0, 64'hDEADBEEF, 1, 4'd0, 64'hDEADBEEF, 1, 4'd0, 4'd0, 64'h0, 0};
      vecs[2] = '{1, 4'd5, 64'h11111111, 1, 4'd5, 64'h22222222, 0, 4'd0, 4'd5, 64'h22222222, 0};
      vecs[3] = '{0, 4'd0, 64'h0, 0, 4'd0, 64'h0, 1, 4'd4, 4'd4, 64'h0, 1};
      vecs[4] = '{0, 4'd0, 64'h0, 1, 4'd4, 64'hAAAA, 0, 4'd0, 4'd4, 64'hAAAA, 0};
      vecs[5] = '{1, 4'd6, 64'h66, 0, 4'd0, 64'h0, 1, 4'd6, 4'd6, 64'h66, 1};
      vecs[6] = '{1, 4'd6, 64'h77, 1, 4'd8, 64'h88, 0, 4'd0, 4'd6, 64'h77, 0};
      vecs[7] = '{0, 4'd0, 64'h0, 0, 4'd0, 64'h0, 0, 4'd0, 4'd8, 64'h88, 0};

      idle();
      bus.raddr = '0;
      model_reset();
      #2;
      check_all_zero("por");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed table: apply one cycle of traffic, then read back with the bus idle.
      for (int v = 0; v < 8; v++) begin
         idle();
         set_w(0, vecs[v].w0_en, vecs[v].w0_addr, vecs[v].w0_data);
         set_w(1, vecs[v].w1_en, vecs[v].w1_addr, vecs[v].w1_data);
         bus.iss_en = vecs[v].iss_en;
         bus.iss_addr = vecs[v].iss_addr;
         tick();
         idle();
         set_rd(vecs[v].rd_addr);
         #1;
         chk($sformatf("vec%0d_rdata", v), bus.rdata[0 +: DW], vecs[v].exp_data);
         chk($sformatf("vec%0d_rbusy", v), DW'(bus.rbusy[0]), DW'(vecs[v].exp_busy));
      end

      // Scoreboard: issue 7, re-issue while completing, then final write clears.
      idle(); set_rd(4'd7);
      bus.iss_en = 1'b1; bus.iss_addr = 4'd7;
      tick(); idle(); #1;
      chk("sb_c1_busy", DW'(bus.rbusy[0]), 64'd1);
      tick(); #1;
      chk("sb_c2_busy", DW'(bus.rbusy[0]), 64'd1);
      set_w(0, 1'b1, 4'd7, 64'h70); bus.iss_en = 1'b1; bus.iss_addr = 4'd7;
      #1;
      chk("sb_c3_same_busy", DW'(bus.rbusy[0]), 64'd1);
      tick(); idle(); #1;
      chk("sb_c4_busy", DW'(bus.rbusy[0]), 64'd1);
      tick();
      set_w(1, 1'b1, 4'd7, 64'h71);
      #1;
      chk("sb_c5_same_busy", DW'(bus.rbusy[0]), BYP ? 64'd0 : 64'd1);
      tick(); idle(); #1;
      chk("sb_c6_busy", DW'(bus.rbusy[0]), 64'd0);
      chk("sb_c6_data", bus.rdata[0 +: DW], 64'h71);

      // Same-cycle write/read of address 9.
      idle(); set_rd(4'd9);
      set_w(0, 1'b1, 4'd9, 64'h5555);
      tick(); idle();
      set_w(1, 1'b1, 4'd9, 64'h0000ABCD);
      #1;
      chk("byp_same_data", bus.rdata[0 +: DW], BYP ? 64'h0000ABCD : 64'h5555);
      chk("byp_same_busy", DW'(bus.rbusy[0]), 64'd0);
      tick(); idle(); #1;
      chk("byp_next_data", bus.rdata[0 +: DW], 64'h0000ABCD);

      // Random traffic; narrow address range on some cycles to force collisions.
      for (int c = 0; c < 10000; c++) begin
         bit narrow;
         narrow = ($urandom_range(0, 3) == 0);
         for (int j = 0; j < NWR; j++) begin
            set_w(j, 1'($urandom_range(0, 1)),
                  narrow ? AW'($urandom_range(0, 2)) : AW'($urandom_range(0, NR - 1)),
                  {$urandom, $urandom});
         end
         bus.iss_en = ($urandom_range(0, 2) == 0);
         bus.iss_addr = narrow ? AW'($urandom_range(0, 2)) : AW'($urandom_range(0, NR - 1));
         for (int i = 0; i < NRD; i++) begin
            bus.raddr[i*AW +: AW] = narrow ? AW'($urandom_range(0, 2)) : AW'($urandom_range(0, NR - 1));
         end
         #1;
         check_ports("rand");
         tick();
      end

      // Asynchronous reset mid-cycle with traffic pending.
      set_w(0, 1'b1, 4'd3, 64'hFFFF);
      bus.iss_en = 1'b1; bus.iss_addr = 4'd3;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all_zero("arst");
      tick();
      check_all_zero("arst_hold");
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_all_zero("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-ported integer register file with a per-register busy scoreboard, the successor to the single-write, dual-read register file in the core. It sits between decode (read and issue ports) and writeback (write ports) and serves pipelined and dual-issue configurations of the NPC. It adds configurable port counts, reset of all architectural state, deterministic write-port priority, optional write-to-read bypass, and pending-write tracking for hazard detection.

## Interface
- `DATA_W`, default 32: register width in bits.
- `NREGS`, default 32: register count (power of 2, ≥ 2); `AW = $clog2(NREGS)`.
- `NRD`, default 2: number of read ports.
- `NWR`, default 1: number of write ports.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low; clears all registers and all busy bits.
- `raddr`  in  NRD×AW: read addresses, one field per port.
- `rdata`  out  NRD×DATA_W: read data, one field per port.
- `rbusy`  out  NRD: 1 when the addressed register has a pending write.
- `wen`  in  NWR: write enables.
- `waddr`  in  NWR×AW: write addresses.
- `wdata`  in  NWR×DATA_W: write data.
- `iss_en`  in  1: mark a register as the destination of an issued instruction.
- `iss_addr`  in  AW: register to mark busy.

## Operation
- Register 0 is hardwired:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 with `rbusy` = 0.
  - `iss_addr` = 0 is ignored.
- Reads are combinational:
  - `rdata[i]` = `regs[raddr[i]]`.
  - `rbusy[i]` = `busy[raddr[i]]`.
- Writes occur on the clock edge when `wen[j]` = 1 and `waddr[j]` ≠ 0.
  - If several ports write the same address in one cycle, the highest-index port wins.
- Scoreboard: one busy bit per register, excluding register 0.
  - `iss_en` sets `busy[iss_addr]`.
  - Any enabled write to address `a` clears `busy[a]`.
  - If a set and a clear hit the same register in the same cycle, the set wins: the new producer supersedes the completing one.
- The scoreboard does not count outstanding writes. A second issue to a busy register leaves it busy, and the first write to that register clears it.
- Reset values:
  - All registers are 0 and all busy bits are 0.
  - So `rdata` = 0 and `rbusy` = 0 for every address immediately after `rst_n` falls, with no clock edge needed.
- Out-of-range addresses cannot occur, because `NREGS` = 2^AW.

## Timing
- Read latency is 0 cycles: a combinational path from `raddr` to `rdata`/`rbusy`.
- Write latency is 1 edge: data written at edge N is visible on the non-bypassed read path after edge N.
- Issue latency is 1 edge: `rbusy` rises after the edge that samples `iss_en`.
- Reset mid-operation: asserting `rst_n` low clears all state asynchronously and discards any in-flight write or issue. While `rst_n` = 0, no state changes on clock edges.
- Reset release is synchronised externally. Inputs must be idle (`wen` = 0, `iss_en` = 0) on the first edge after release.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Each read port compares `raddr[i]` against every enabled write port in the same cycle.
  - On a match with a nonzero address, `rdata[i]` returns that port's `wdata`, with the highest-index port taking precedence.
  - `rbusy[i]` is forced to 0, unless `iss_en` targets the same register in that cycle.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return the stored value only.
  - A same-cycle write is visible from the next cycle, and `rbusy` stays 1 until the clearing edge.

## Test plan
- Reset: hold `rst_n` = 0 after random writes -> all `rdata` = 0 and all `rbusy` = 0 asynchronously. After release, read every address -> 0.
- Register 0: write `32'hDEADBEEF` to address 0 and issue to address 0 -> `rdata` = 0 and `rbusy` = 0 on the next cycle.
- Write priority (`NWR` = 2): port0 writes `32'h11111111` and port1 writes `32'h22222222` to address 5 in the same cycle -> the next-cycle read of address 5 = `32'h22222222`.
- Scoreboard: issue address 7 at cycle 0 -> `rbusy` = 1 from cycle 1. Write address 7 at cycle 3 while issuing address 7 again -> still busy. Write address 7 at cycle 5 -> `rbusy` = 0 from cycle 6.
- Bypass: write `32'h0000ABCD` to address 9 while reading address 9.
  - With `REGFILE_BYPASS_EN`: `rdata` = `32'h0000ABCD` and `rbusy` = 0 in the same cycle.
  - Without it: `rdata` = the old value in that cycle and `32'h0000ABCD` on the next.
- Parameter sweep: `NREGS` = 16, `DATA_W` = 64, `NRD` = 3, `NWR` = 2. Random traffic checked against a reference model -> no mismatches over 10k cycles.
